// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: 32-bit unsigned in, 8 packed BCD digits out.
// Define BIN2BCD_OVF_ERR_EN to show 0xEEEEEEEE instead of the mod-10^8 result on overflow.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] bcd_out,
   output logic        ovf
);

   localparam logic [31:0] OvfLimit = 32'h05F5_E0FF;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   state_t      state;
   logic [31:0] shift_reg;
   logic [31:0] acc;
   logic [31:0] acc_adj;
   logic [4:0]  cnt;
   logic        ovf_next;

   // Add 3 to every nibble >= 5 so the following shift carries correctly into the next digit.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 8; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd_out   <= '0;
         ovf       <= 1'b0;
         cnt       <= '0;
         shift_reg <= '0;
         acc       <= '0;
         ovf_next  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  shift_reg <= bin_in;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf_next  <= (bin_in > OvfLimit);
                  busy      <= 1'b1;
                  state     <= StShift;
               end
            end
            StShift: begin
               // Carry out of acc[31] is dropped, which yields the value mod 10^8.
               acc       <= {acc_adj[30:0], shift_reg[31]};
               shift_reg <= {shift_reg[30:0], 1'b0};
               cnt       <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= StDone;
               end
            end
            StDone: begin
`ifdef BIN2BCD_OVF_ERR_EN
               bcd_out <= ovf_next ? 32'hEEEE_EEEE : acc;
`else
               bcd_out <= acc;
`endif
               ovf   <= ovf_next;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed and random conversions against a decimal model.
module tb_bin2bcd_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] bin_in;
   logic        busy;
   logic        done;
   logic [31:0] bcd_out;
   logic        ovf;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   logic [31:0] hold_bcd;
   logic        hold_ovf;

   bin2bcd_seq dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal reference: digit extraction by plain division.
   function automatic logic [31:0] model_bcd(input logic [31:0] v);
      logic [31:0]     r;
      longint unsigned x;
      r = '0;
      x = longint'(v) % 64'd100000000;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef BIN2BCD_OVF_ERR_EN
      if (longint'(v) > 64'd99999999) r = 32'hEEEE_EEEE;
`endif
      return r;
   endfunction

   function automatic logic model_ovf(input logic [31:0] v);
      return longint'(v) > 64'd99999999;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Launch at edge E, check the busy window E+1..E+32, then result at E+33 and E+34.
   task automatic run_conv(input logic [31:0] v, input bit scramble);
      bit ok;
      bin_in = v;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", {31'b0, busy}, 32'd1);
      ok = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         if (scramble) begin
            bin_in = $urandom;
            start  = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b1 || bcd_out !== hold_bcd || ovf !== hold_ovf) ok = 1'b0;
      end
      start = 1'b0;
      chk("busy_window_hold", {31'b0, ok}, 32'd1);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("busy_clear", {31'b0, busy}, 32'd0);
      chk("bcd_result", bcd_out, model_bcd(v));
      chk("ovf_result", {31'b0, ovf}, {31'b0, model_ovf(v)});
      hold_bcd = model_bcd(v);
      hold_ovf = model_ovf(v);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("bcd_stable", bcd_out, hold_bcd);
   endtask

   initial begin
      logic [31:0] v0;
      logic [31:0] v1;
      bit          ok;
      int          done_seen;

      reset    = 1'b1;
      start    = 1'b0;
      bin_in   = '0;
      hold_bcd = '0;
      hold_ovf = 1'b0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_bcd", bcd_out, 32'd0);
      chk("rst_ovf", {31'b0, ovf}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_conv(32'h0000_0000, 1'b0);
      run_conv(32'h00BC_614E, 1'b0);
      chk("dir_12345678", hold_bcd, 32'h1234_5678);
      run_conv(32'h05F5_E0FF, 1'b1);
      run_conv(32'h05F5_E100, 1'b0);
      run_conv(32'hFFFF_FFFF, 1'b0);
`ifdef BIN2BCD_OVF_ERR_EN
      chk("dir_ffffffff", hold_bcd, 32'hEEEE_EEEE);
`else
      chk("dir_ffffffff", hold_bcd, 32'h9496_7295);
`endif
      for (int n = 0; n < 6; n++) begin
         run_conv($urandom_range(0, 99999999), 1'b1);
      end
      for (int n = 0; n < 3; n++) begin
         run_conv($urandom, 1'b1);
      end

      // start held high for 40 edges while bin_in changes every cycle
      v0     = $urandom_range(0, 99999999);
      bin_in = v0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      ok = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         bin_in = $urandom;
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      chk("held_start_window", {31'b0, ok}, 32'd1);
      bin_in = $urandom;
      @(posedge clk);
      #1;
      chk("held_done", {31'b0, done}, 32'd1);
      chk("held_bcd", bcd_out, model_bcd(v0));
      hold_bcd = model_bcd(v0);
      hold_ovf = model_ovf(v0);
      v1     = $urandom_range(0, 99999999);
      bin_in = v1;
      @(posedge clk);
      #1;
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      chk("b2b_done_low", {31'b0, done}, 32'd0);
      ok = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         if (k == 6) start = 1'b0;
         bin_in = $urandom;
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b1 || bcd_out !== hold_bcd) ok = 1'b0;
      end
      chk("b2b_window", {31'b0, ok}, 32'd1);
      @(posedge clk);
      #1;
      chk("b2b_done", {31'b0, done}, 32'd1);
      chk("b2b_bcd", bcd_out, model_bcd(v1));
      hold_bcd = model_bcd(v1);
      hold_ovf = model_ovf(v1);
      @(posedge clk);
      #1;

      // reset in the middle of a conversion of 12345678
      bin_in = 32'h00BC_614E;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_bcd", bcd_out, 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      hold_bcd = '0;
      hold_ovf = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy !== 1'b0) done_seen++;
      end
      chk("abort_no_done", done_seen, 32'd0);
      run_conv(32'h00BC_614E, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: observed no end expected finish");
      $fatal(1, "timeout");
   end

endmodule
